// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter that shares one AES core between two requesters.
// It supports lock-based ownership across blocks and a WAIT-state watchdog.
module aes_core_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int WORD_S         = 32,
  parameter int KEY_S          = 128,
  parameter int BLK_S          = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [WORD_S-1:0] cmd0,
  input  logic [WORD_S-1:0] cmd1,
  input  logic [KEY_S-1:0]  key0,
  input  logic [KEY_S-1:0]  key1,
  input  logic [BLK_S-1:0]  blk0,
  input  logic [BLK_S-1:0]  blk1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [BLK_S-1:0]  rsp_blk,
  output logic              busy,
  output logic              core_en,
  output logic [WORD_S-1:0] core_cmd,
  output logic [KEY_S-1:0]  core_key,
  output logic [BLK_S-1:0]  core_blk,
  input  logic [BLK_S-1:0]  core_blk_out,
  input  logic              core_done
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t            r_state, w_state;
  logic              r_last, w_last;
  logic              r_locked, w_locked;
  logic              r_owner, w_owner;
  logic [15:0]       r_cnt, w_cnt;
  logic [1:0]        r_gnt, w_gnt;
  logic [1:0]        r_done, w_done;
  logic [1:0]        r_err, w_err;
  logic              r_core_en, w_core_en;
  logic [WORD_S-1:0] r_cmd, w_cmd;
  logic [KEY_S-1:0]  r_key, w_key;
  logic [BLK_S-1:0]  r_blk, w_blk;
  logic [BLK_S-1:0]  r_rsp, w_rsp;
  logic              r_busy, w_busy;

  logic [1:0]        w_req, w_lock, w_elig;
  logic              w_sel;

  assign w_req  = {req1, req0};
  assign w_lock = {lock1, lock0};

  always_comb begin
    w_state   = r_state;
    w_last    = r_last;
    w_locked  = r_locked;
    w_owner   = r_owner;
    w_cnt     = r_cnt;
    w_gnt     = r_gnt;
    w_done    = '0;
    w_err     = '0;
    w_core_en = 1'b0;
    w_cmd     = r_cmd;
    w_key     = r_key;
    w_blk     = r_blk;
    w_rsp     = r_rsp;
    w_elig    = '0;
    w_sel     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Release a lock the owner no longer asserts, then arbitrate in the same cycle.
        if (r_locked && !w_lock[r_owner]) begin
          w_locked = 1'b0;
          w_gnt    = '0;
        end
        w_elig = w_locked ? (w_req & {r_owner, ~r_owner}) : w_req;
        w_sel  = (&w_elig) ? ~r_last : w_elig[1];
        if (|w_elig) begin
          w_state   = S_ISSUE;
          w_gnt     = {w_sel, ~w_sel};
          w_last    = w_sel;
          w_owner   = w_sel;
          w_locked  = w_lock[w_sel];
          w_cnt     = '0;
          w_core_en = 1'b1;
          w_cmd     = w_sel ? cmd1 : cmd0;
          w_key     = w_sel ? key1 : key0;
          w_blk     = w_sel ? blk1 : blk0;
        end
      end
      S_ISSUE: w_state = S_WAIT;
      S_WAIT: begin
        // A completion in the timeout cycle still counts as success.
        if (core_done) begin
          w_state         = S_RESPOND;
          w_rsp           = core_blk_out;
          w_done[r_owner] = 1'b1;
          if (!r_locked) w_gnt = '0;
        end else if (r_cnt == TO_LAST) begin
          w_state        = S_RESPOND;
          w_err[r_owner] = 1'b1;
          w_locked       = 1'b0;
          w_gnt          = '0;
        end else begin
          w_cnt = r_cnt + 16'd1;
        end
      end
      S_RESPOND: w_state = S_IDLE;
      default:   w_state = S_IDLE;
    endcase
    w_busy = (w_state != S_IDLE) || w_locked;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_locked  <= 1'b0;
      r_owner   <= 1'b0;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_err     <= '0;
      r_core_en <= 1'b0;
      r_cmd     <= '0;
      r_key     <= '0;
      r_blk     <= '0;
      r_rsp     <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_last    <= w_last;
      r_locked  <= w_locked;
      r_owner   <= w_owner;
      r_cnt     <= w_cnt;
      r_gnt     <= w_gnt;
      r_done    <= w_done;
      r_err     <= w_err;
      r_core_en <= w_core_en;
      r_cmd     <= w_cmd;
      r_key     <= w_key;
      r_blk     <= w_blk;
      r_rsp     <= w_rsp;
      r_busy    <= w_busy;
    end
  end

  assign gnt0     = r_gnt[0];
  assign gnt1     = r_gnt[1];
  assign done0    = r_done[0];
  assign done1    = r_done[1];
  assign err0     = r_err[0];
  assign err1     = r_err[1];
  assign rsp_blk  = r_rsp;
  assign busy     = r_busy;
  assign core_en  = r_core_en;
  assign core_cmd = r_cmd;
  assign core_key = r_key;
  assign core_blk = r_blk;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter: a default-timeout instance with a latency
// core model, and a TIMEOUT_CYCLES=8 instance driven by hand for watchdog cases.
module tb_aes_core_arbiter;

  localparam logic [31:0]  CBC_ENCRYPT_128 = 32'h0000_0003;
  localparam logic [31:0]  CMD_B = 32'h0000_0004;
  localparam logic [127:0] K0 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] B0 = 128'h6bc1bee2_2e409f96_e93d7e11_7393172a;
  localparam logic [127:0] K1 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] B1 = 128'hdeadbeef_01234567_89abcdef_cafef00d;
  localparam logic [127:0] PAT_A = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] PAT_B = 128'h55555555_66666666_77777777_88888888;
  localparam logic [127:0] PAT_C = 128'h99999999_aaaaaaaa_bbbbbbbb_cccccccc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         req0, req1, lock0, lock1;
  logic [31:0]  cmd0, cmd1;
  logic [127:0] key0, key1, blk0, blk1;
  logic         gnt0, gnt1, done0, done1, err0, err1, busy, core_en;
  logic [127:0] rsp_blk, core_key, core_blk, core_blk_out;
  logic [31:0]  core_cmd;
  logic         core_done;

  logic         t_req0, t_req1;
  logic         t_gnt0, t_gnt1, t_done0, t_done1, t_err0, t_err1, t_busy, t_core_en;
  logic [127:0] t_rsp_blk, t_core_key, t_core_blk, t_core_blk_out;
  logic [31:0]  t_core_cmd;
  logic         t_core_done;

  aes_core_arbiter u_dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .cmd0(cmd0), .cmd1(cmd1), .key0(key0), .key1(key1), .blk0(blk0), .blk1(blk1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .rsp_blk(rsp_blk), .busy(busy), .core_en(core_en),
    .core_cmd(core_cmd), .core_key(core_key), .core_blk(core_blk),
    .core_blk_out(core_blk_out), .core_done(core_done)
  );

  aes_core_arbiter #(.TIMEOUT_CYCLES(8)) u_dut8 (
    .clk(clk), .reset(reset),
    .req0(t_req0), .req1(t_req1), .lock0(1'b0), .lock1(1'b0),
    .cmd0(cmd0), .cmd1(cmd1), .key0(key0), .key1(key1), .blk0(blk0), .blk1(blk1),
    .gnt0(t_gnt0), .gnt1(t_gnt1), .done0(t_done0), .done1(t_done1), .err0(t_err0), .err1(t_err1),
    .rsp_blk(t_rsp_blk), .busy(t_busy), .core_en(t_core_en),
    .core_cmd(t_core_cmd), .core_key(t_core_key), .core_blk(t_core_blk),
    .core_blk_out(t_core_blk_out), .core_done(t_core_done)
  );

  int n_chk = 0, n_err = 0;
  int cyc = 0, n_both = 0, n_de = 0;
  int lat = 0, mcnt = 0;
  logic [127:0] m_blk, m_key;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Core model: completes lat cycles after core_en, result = block ^ key.
  initial begin
    core_done = 1'b0;
    core_blk_out = '0;
    m_blk = '0;
    m_key = '0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          core_done = 1'b1;
          core_blk_out = m_blk ^ m_key;
        end
      end
      if (core_en && lat > 0) begin
        mcnt = lat;
        m_blk = core_blk;
        m_key = core_key;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if ((gnt0 && gnt1) || (t_gnt0 && t_gnt1)) n_both++;
      if (((done0 || done1) && (err0 || err1)) || ((t_done0 || t_done1) && (t_err0 || t_err1))) n_de++;
    end
  end

  initial begin
    int T, R, nops, nd0, nd1, ng, ng1, got;
    int gord[4];
    int dord[4];
    reset = 1'b0;
    {req0, req1, lock0, lock1, t_req0, t_req1, t_core_done} = '0;
    cmd0 = '0; cmd1 = '0; key0 = '0; key1 = '0; blk0 = '0; blk1 = '0;
    t_core_blk_out = '0;
    for (int k = 0; k < 4; k++) begin gord[k] = -1; dord[k] = -1; end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ctl", {gnt1, gnt0, done1, done0, err1, err0, core_en, busy}, 0);
    chk("rst_cmd", core_cmd, 0);
    chk("rst_key", core_key, 0);
    chk("rst_blk", core_blk, 0);
    chk("rst_rsp", rsp_blk, 0);
    chk("rst_t_ctl", {t_gnt1, t_gnt0, t_done1, t_done0, t_err1, t_err0, t_core_en, t_busy}, 0);
    reset = 1'b1;

    // Completion exactly in the timeout cycle wins over the timeout
    @(negedge clk);
    T = cyc;
    t_req0 = 1'b1; cmd0 = CBC_ENCRYPT_128; key0 = K0; blk0 = B0;
    repeat (9) @(negedge clk);
    chk("bnd_quiet", {t_err0, t_done0}, 2'b00);
    t_core_done = 1'b1; t_core_blk_out = PAT_A;
    @(negedge clk);
    t_core_done = 1'b0;
    chk("bnd_cycle", cyc - T, 10);
    chk("bnd_done", {t_done0, t_err0}, 2'b10);
    chk("bnd_rsp", t_rsp_blk, PAT_A);
    chk("bnd_gnt", t_gnt0, 0);
    t_req0 = 1'b0;

    // Stray completion in IDLE
    repeat (2) @(negedge clk);
    t_core_done = 1'b1; t_core_blk_out = PAT_B;
    @(negedge clk);
    t_core_done = 1'b0;
    chk("stray_ctl", {t_gnt1, t_gnt0, t_done1, t_done0, t_err1, t_err0, t_core_en, t_busy}, 0);
    chk("stray_rsp", t_rsp_blk, PAT_A);

    // Timeout with the core never completing, then a late completion
    @(negedge clk);
    T = cyc;
    t_req1 = 1'b1; cmd1 = CMD_B; key1 = K1; blk1 = B1;
    repeat (9) @(negedge clk);
    chk("to_early", t_err1, 0);
    @(negedge clk);
    chk("to_err", {t_err1, t_done1}, 2'b10);
    chk("to_gnt", t_gnt1, 0);
    t_req1 = 1'b0;
    repeat (3) @(negedge clk);
    t_core_done = 1'b1; t_core_blk_out = PAT_C;
    @(negedge clk);
    t_core_done = 1'b0;
    chk("late_ctl", {t_gnt1, t_gnt0, t_done1, t_done0, t_err1, t_err0, t_busy}, 0);
    chk("late_rsp", t_rsp_blk, PAT_A);

    // Single request, core latency 10
    lat = 10;
    @(negedge clk);
    T = cyc;
    req0 = 1'b1; cmd0 = CBC_ENCRYPT_128; key0 = K0; blk0 = B0;
    @(negedge clk);
    chk("iss_ctl", {gnt1, gnt0, core_en}, 3'b011);
    chk("iss_cmd", core_cmd, CBC_ENCRYPT_128);
    chk("iss_key", core_key, K0);
    chk("iss_blk", core_blk, B0);
    repeat (10) @(negedge clk);
    chk("one_early", done0, 0);
    @(negedge clk);
    chk("one_cycle", cyc - T, 12);
    chk("one_done", {done0, done1, err0}, 3'b100);
    chk("one_rsp", rsp_blk, B0 ^ K0);
    chk("one_gnt", gnt0, 0);
    req0 = 1'b0;
    @(negedge clk);
    chk("one_idle", busy, 0);

    // Tie and rotation: last-served pointer back to 1 via reset
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    lat = 3;
    key1 = K1; blk1 = B1;
    req0 = 1'b1; req1 = 1'b1;
    nops = 0; nd0 = 0; nd1 = 0; ng = 0;
    for (int i = 0; i < 200 && nops < 4; i++) begin
      @(negedge clk);
      if (core_en && ng < 4) begin gord[ng] = int'(gnt1); ng++; end
      if (done0 || done1) begin
        if (nops < 4) begin
          dord[nops] = int'(done1);
          chk("rot_rsp", rsp_blk, (nops % 2) ? (B1 ^ K1) : (B0 ^ K0));
        end
        nops++;
        if (done0) begin nd0++; if (nd0 == 2) req0 = 1'b0; end
        if (done1) begin nd1++; if (nd1 == 2) req1 = 1'b0; end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("rot_ops", nops, 4);
    for (int k = 0; k < 4; k++) begin
      chk("rot_gnt", gord[k], k % 2);
      chk("rot_owner", dord[k], k % 2);
    end

    // Lock: requester 0 keeps the core for three blocks while 1 waits
    @(negedge clk);
    req0 = 1'b1; lock0 = 1'b1; req1 = 1'b1;
    nd0 = 0; ng1 = 0;
    for (int i = 0; i < 300 && nd0 < 3; i++) begin
      @(negedge clk);
      if (gnt1) ng1++;
      if (done0) begin
        nd0++;
        if (nd0 == 1) chk("lock_hold", gnt0, 1);
        if (nd0 == 3) begin req0 = 1'b0; lock0 = 1'b0; end
      end
    end
    chk("lock_blocks", nd0, 3);
    chk("lock_no_gnt1", ng1, 0);
    R = cyc;
    @(negedge clk);
    @(negedge clk);
    chk("lock_handover", {gnt1, gnt0, core_en}, 3'b101);
    chk("lock_cycle", cyc - R, 2);
    got = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done1) begin got = 1; break; end
    end
    chk("lock_done1", got, 1);
    chk("lock_rsp1", rsp_blk, B1 ^ K1);
    req1 = 1'b0;

    // Reset mid-WAIT with a lock held
    lat = 0;
    @(negedge clk);
    @(negedge clk);
    req0 = 1'b1; lock0 = 1'b1;
    @(negedge clk);
    chk("rw_issue", {gnt0, core_en}, 2'b11);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; req0 = 1'b0;
    chk("rw_ctl", {gnt1, gnt0, done1, done0, err1, err0, core_en, busy}, 0);
    chk("rw_key", core_key, 0);
    chk("rw_rsp", rsp_blk, 0);
    repeat (2) @(negedge clk);
    chk("rw_unlocked", {busy, gnt0, done0, err0}, 0);
    lat = 3;
    T = cyc;
    req1 = 1'b1;
    @(negedge clk);
    chk("rw_next_iss", {gnt1, core_en}, 2'b11);
    chk("rw_next_blk", core_blk, B1);
    repeat (4) @(negedge clk);
    chk("rw_next_done", {done1, cyc - T}, {1'b1, 32'd5});
    chk("rw_next_rsp", rsp_blk, B1 ^ K1);
    req1 = 1'b0; lock0 = 1'b0;
    repeat (2) @(negedge clk);

    chk("gnt_excl", n_both, 0);
    chk("done_err_excl", n_de, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_core_arbiter.md
# aes_core_arbiter

Shares one `aes_top` encryption core between two requesters: for example, two `aes_controller`-style sequencers, or a controller plus a key-management engine. The arbiter grants the core round-robin and registers the winner's command, key and block. It pulses the core start, waits for the core's completion, and routes the result back to the owner. A lock lets one requester keep the core across consecutive blocks, which CBC chaining and key reuse need. A watchdog aborts operations the core never completes.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 64: number of WAIT cycles without `core_done` before the operation is aborted (range 2..65535).

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-low reset: `reset == 0` at a rising edge resets the block
- `req0`, `req1`  in  1  level request; held until the matching `done`/`err` pulse
- `lock0`, `lock1`  in  1  keep ownership after the current operation completes
- `cmd0`, `cmd1`  in  `WORD_S` (32)  AES command (`CBC_ENCRYPT_128` etc.)
- `key0`, `key1`  in  `KEY_S` (128)  key
- `blk0`, `blk1`  in  `BLK_S` (128)  input block; `cmdN`/`keyN`/`blkN` stable while `reqN` is high and `gntN` is low
- `gnt0`, `gnt1`  out  1  requester owns the core
- `done0`, `done1`  out  1  one-cycle pulse: result is valid on `rsp_blk`
- `err0`, `err1`  out  1  one-cycle pulse: operation aborted by timeout
- `rsp_blk`  out  `BLK_S`  result; holds its value until the next completion
- `busy`  out  1  state is not IDLE, or a lock is held
- `core_en`  out  1  one-cycle start pulse to `aes_top.en`
- `core_cmd`, `core_key`, `core_blk`  out  32/128/128  registered operands to the core
- `core_blk_out`  in  `BLK_S`  `aes_top.aes_out_blk`
- `core_done`  in  1  `aes_top.en_o`

## Operation
- States: IDLE, ISSUE, WAIT, RESPOND. Unused encodings go to IDLE.
- IDLE, arbitration:
  - With no lock held: if exactly one `reqN` is high, grant N.
  - If both are high, grant the requester other than `last` (1-bit last-served pointer; reset value 1, so requester 0 wins the first tie).
  - If `owner_locked` is set: only the owner's `req` is considered. The other requester waits; its `gnt` stays low.
- On grant (IDLE→ISSUE edge):
  - Register `cmdN`/`keyN`/`blkN` into `core_*`.
  - Set `gntN=1`, `last<=N`, `owner_locked<=lockN`.
  - Clear the timeout counter.
- ISSUE: `core_en=1` for exactly this cycle, then go to WAIT.
- WAIT: the counter increments each cycle `core_done` is low.
  - If `core_done` is high: capture `core_blk_out` into `rsp_blk` and go to RESPOND (ok).
  - Else, if counter == `TIMEOUT_CYCLES-1`: go to RESPOND (error) and clear `owner_locked`.
  - If `core_done` arrives in the same cycle as the timeout, `core_done` wins.
- RESPOND: pulse `doneN` (ok) or `errN` (error) for one cycle. Requests are not sampled in this cycle. Go to IDLE.
  - Ok and `owner_locked` set: `gntN` stays 1.
  - Otherwise: `gntN` drops to 0 in this cycle.
- Lock release: in IDLE with owner N, if `lockN` is low, clear `owner_locked` and drop `gntN`. Normal arbitration runs in the same cycle.
- `core_done` is ignored in IDLE, ISSUE and RESPOND (stray or late completions).
- `gnt0` and `gnt1` are never both 1. `done*` and `err*` are mutually exclusive.

## Timing
- Reset values: state IDLE, `last=1`, `owner_locked=0`, counter 0. All outputs are 0: `gnt*`, `done*`, `err*`, `core_en`, `core_*`, `rsp_blk`, `busy`.
- Reset mid-operation aborts silently: no `done`/`err` pulse. A core completion after reset lands in IDLE and is ignored.
- `reqN` high at cycle T in IDLE gives:
  - cycle T+1: `gntN=1`, `core_en=1`, operands valid.
  - cycle T+2 onward: WAIT.
- `core_done` at cycle M gives `doneN` and the new `rsp_blk` at cycle M+1.
- Earliest re-arbitration is M+2, so back-to-back issue has a 3-cycle gap between `core_done` and the next `core_en`.
- Timeout: with no `core_done`, `errN` fires at T+2+`TIMEOUT_CYCLES`.
- Every output is registered; there is no combinational input-to-output path.

## Test plan
- Single request: reset low for 2 cycles, then `req0=1` with cmd `CBC_ENCRYPT_128`, key `2b7e1516_28aed2a6_abf71588_09cf4f3c`, blk `6bc1bee2_2e409f96_e93d7e11_7393172a`; model core `done` 10 cycles after `core_en` -> `core_en` at T+1 with the exact operands, `done0` at T+12, `rsp_blk` = model output, `gnt0` low at T+12.
- Tie and rotation: `req0` and `req1` rise in the same cycle and are held for 4 operations -> grants in order 0,1,0,1; each `doneN` goes to the matching owner; `gnt0 & gnt1` is never 1.
- Lock: `req0` with `lock0=1` for 3 blocks while `req1` stays high -> three `done0` pulses with no `gnt1`. Dropping `lock0` in IDLE -> `gnt1` within 1 cycle, then `done1`.
- Timeout: `TIMEOUT_CYCLES=8`, core never completes -> `err1` at T+10 and no `done1`; a `core_done` injected 3 cycles later is ignored and `rsp_blk` is unchanged.
- Boundary: `core_done` in the exact timeout cycle -> `done` pulses, not `err`. A stray `core_done` in IDLE produces no output change.
- Reset mid-WAIT: drive `reset=0` for 1 cycle during WAIT -> all outputs 0 on the next cycle, lock cleared, no pulse, and the next request is served normally.
